// File: rtl/check_origin_axis_if.sv
// AXI-stream bundle shared by the origin-stream generator (master) and checker (slave).
interface axi_stream_inf #(
  parameter int DSIZE = 32
) (
  input logic aclk
);
  logic             aresetn;
  logic             aclken;
  logic             tvalid;
  logic             tready;
  logic [DSIZE-1:0] tdata;
  logic             tlast;

  modport master (input aclk, output aresetn, aclken, tvalid, tdata, tlast, input tready);
  modport slave  (input aclk, aresetn, aclken, tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/check_origin_axis.sv
// Receive-side checker for origin test streams: per-frame data/length verdict plus statistics.
// Optional CHECK_ORIGIN_BP_EN gates tready in RECV with an LFSR to exercise upstream stalls.
module check_origin_axis #(
  parameter string MODE  = "RANGE",
  parameter int    DSIZE = 32
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         enable,
  output logic         ready,
  input  logic [31:0]  length,
  input  logic [31:0]  start,
  axi_stream_inf.slave axis_in,
  output logic         done,
  output logic         pass,
  output logic         err_data,
  output logic         err_len,
  output logic [31:0]  err_index,
  output logic [31:0]  frame_cnt,
  output logic [15:0]  fail_cnt
);

  localparam bit FIXED_MODE = (MODE == "FIXED");

  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

  state_t      state, state_next;
  logic [31:0] lock_len, exp_val, beat_cnt, last_idx;
  logic        tready_int, bp_ok, arm, beat, mismatch, len_bad;

  // aclk is the same net as clock and aresetn is deliberately ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, axis_in.aclk, axis_in.aresetn};

`ifdef CHECK_ORIGIN_BP_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1, free-running so stall patterns do not repeat per frame.
  always_ff @(posedge clock) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign bp_ok = lfsr[0];
`else
  assign bp_ok = 1'b1;
`endif

  assign arm      = enable && ready;
  assign beat     = (state == RECV) && axis_in.tvalid && tready_int && axis_in.aclken;
  assign mismatch = (axis_in.tdata != exp_val[DSIZE-1:0]);
  assign last_idx = lock_len - 32'd1;
  assign len_bad  = axis_in.tlast ? (beat_cnt != last_idx) : (beat_cnt >= last_idx);
  assign axis_in.tready = tready_int;

  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (arm) state_next = RECV;
      RECV:    if (beat && axis_in.tlast) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are gated by rst so everything reads 0 while reset is held.
  always_comb begin
    ready      = 1'b0;
    tready_int = 1'b0;
    done       = 1'b0;
    if (!rst) begin
      ready      = (state == IDLE);
      tready_int = (state == RECV) && bp_ok;
      done       = (state == REPORT);
    end
    pass = done && !err_data && !err_len;
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      lock_len  <= '0;
      exp_val   <= '0;
      beat_cnt  <= '0;
      err_data  <= 1'b0;
      err_len   <= 1'b0;
      err_index <= '0;
      frame_cnt <= '0;
      fail_cnt  <= '0;
    end else begin
      if (arm) begin
        lock_len  <= (length == 32'd0) ? 32'd1 : length;
        exp_val   <= start;
        beat_cnt  <= '0;
        err_data  <= 1'b0;
        err_len   <= 1'b0;
        err_index <= '0;
      end
      if (beat) begin
        if (mismatch && !err_data) begin
          err_data  <= 1'b1;
          err_index <= beat_cnt;
        end
        if (len_bad) err_len <= 1'b1;
        if (!FIXED_MODE) exp_val <= exp_val + 32'd1;
        beat_cnt <= beat_cnt + 32'd1;
      end
      if (state == REPORT) begin
        frame_cnt <= frame_cnt + 32'd1;
        if ((err_data || err_len) && (fail_cnt != 16'hFFFF))
          fail_cnt <= fail_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_check_origin_axis.sv
// Directed bench for check_origin_axis: one RANGE and one FIXED instance share the stream wires.
module tb_check_origin_axis;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, enable, sel;
  logic [31:0]   length, start;
  logic          tvalid, aclken, tlast;
  logic [DW-1:0] tdata;

  always #5 clk = ~clk;

  axi_stream_inf #(.DSIZE(DW)) ax_r (.aclk(clk));
  axi_stream_inf #(.DSIZE(DW)) ax_f (.aclk(clk));

  assign ax_r.aresetn = 1'b1;
  assign ax_r.aclken  = aclken;
  assign ax_r.tvalid  = tvalid;
  assign ax_r.tdata   = tdata;
  assign ax_r.tlast   = tlast;
  assign ax_f.aresetn = 1'b1;
  assign ax_f.aclken  = aclken;
  assign ax_f.tvalid  = tvalid;
  assign ax_f.tdata   = tdata;
  assign ax_f.tlast   = tlast;

  logic        r_ready, r_done, r_pass, r_err_data, r_err_len;
  logic [31:0] r_err_index, r_frame_cnt;
  logic [15:0] r_fail_cnt;
  logic        f_ready, f_done, f_pass, f_err_data, f_err_len;
  logic [31:0] f_err_index, f_frame_cnt;
  logic [15:0] f_fail_cnt;

  check_origin_axis #(.MODE("RANGE"), .DSIZE(DW)) dut_range (
    .clock(clk), .rst(rst), .enable(enable && !sel), .ready(r_ready),
    .length(length), .start(start), .axis_in(ax_r),
    .done(r_done), .pass(r_pass), .err_data(r_err_data), .err_len(r_err_len),
    .err_index(r_err_index), .frame_cnt(r_frame_cnt), .fail_cnt(r_fail_cnt)
  );

  check_origin_axis #(.MODE("FIXED"), .DSIZE(DW)) dut_fixed (
    .clock(clk), .rst(rst), .enable(enable && sel), .ready(f_ready),
    .length(length), .start(start), .axis_in(ax_f),
    .done(f_done), .pass(f_pass), .err_data(f_err_data), .err_len(f_err_len),
    .err_index(f_err_index), .frame_cnt(f_frame_cnt), .fail_cnt(f_fail_cnt)
  );

  // Outputs of whichever instance the current frame targets.
  logic        ready_m, tready_m, done_m, pass_m, err_data_m, err_len_m;
  logic [31:0] err_index_m, frame_cnt_m;
  logic [15:0] fail_cnt_m;
  assign ready_m     = sel ? f_ready     : r_ready;
  assign tready_m    = sel ? ax_f.tready : ax_r.tready;
  assign done_m      = sel ? f_done      : r_done;
  assign pass_m      = sel ? f_pass      : r_pass;
  assign err_data_m  = sel ? f_err_data  : r_err_data;
  assign err_len_m   = sel ? f_err_len   : r_err_len;
  assign err_index_m = sel ? f_err_index : r_err_index;
  assign frame_cnt_m = sel ? f_frame_cnt : r_frame_cnt;
  assign fail_cnt_m  = sel ? f_fail_cnt  : r_fail_cnt;

  typedef struct {
    bit          fixed;
    logic [31:0] start;
    logic [31:0] length;
    int          nbeats;
    int          bad_idx;
    logic [15:0] bad_val;
    bit          stall;
    bit          exp_pass;
    bit          exp_err_data;
    bit          exp_err_len;
    logic [31:0] exp_idx;
  } vec_t;

  vec_t        vecs[11];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_frames[2];
  logic [15:0] exp_fails[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input bit fixed, input logic [31:0] st, input logic [31:0] len);
    sel    = fixed;
    start  = st;
    length = len;
    enable = 1'b1;
    @(negedge clk);
    check("arm ready", ready_m, 1);
    tick();
    enable = 1'b0;
    check("armed ready low", ready_m, 0);
    check("armed tready", tready_m, 1);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit stall);
    bit got;
    if (stall) begin
      // Garbage with aclken low, then a bubble: neither may be counted or compared.
      tvalid = 1'b1; aclken = 1'b0; tdata = 16'hDEAD; tlast = 1'b1;
      tick();
      tvalid = 1'b0; aclken = 1'b1; tdata = 16'hBEEF;
      tick();
    end
    tvalid = 1'b1; aclken = 1'b1; tdata = d; tlast = last;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (tready_m) got = 1'b1;
      tick();
    end
    if (!got) check("beat handshake timeout", 0, 1);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] d32;
    int          s;
    s = v.fixed ? 1 : 0;
    arm(v.fixed, v.start, v.length);
    for (int i = 0; i < v.nbeats; i++) begin
      d32 = v.fixed ? v.start : v.start + 32'(i);
      if (i == v.bad_idx) d32 = {16'h0, v.bad_val};
      send_beat(d32[DW-1:0], i == v.nbeats - 1, v.stall);
    end
    // Now in the cycle right after the tlast beat.
    check("done strobe", done_m, 1);
    check("report tready", tready_m, 0);
    check("pass", pass_m, v.exp_pass);
    check("err_data", err_data_m, v.exp_err_data);
    check("err_len", err_len_m, v.exp_err_len);
    check("err_index", err_index_m, v.exp_idx);
    exp_frames[s] = exp_frames[s] + 32'd1;
    if (!v.exp_pass) exp_fails[s] = exp_fails[s] + 16'd1;
    tick();
    check("done single cycle", done_m, 0);
    check("ready back", ready_m, 1);
    check("frame_cnt", frame_cnt_m, exp_frames[s]);
    check("fail_cnt", fail_cnt_m, exp_fails[s]);
    check("err_data held", err_data_m, v.exp_err_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    //            fixed start          len    nb bad bad_v   stl pass ed el idx
    vecs[0]  = '{0, 32'h0000_0010, 32'd4, 4, -1, 16'h0,  0, 1, 0, 0, 32'd0};
    vecs[1]  = '{0, 32'h0000_0007, 32'd1, 1, -1, 16'h0,  0, 1, 0, 0, 32'd0};
    vecs[2]  = '{0, 32'h0000_0007, 32'd0, 1, -1, 16'h0,  0, 1, 0, 0, 32'd0};
    vecs[3]  = '{0, 32'h0000_0000, 32'd5, 5,  2, 16'hFF, 0, 0, 1, 0, 32'd2};
    vecs[4]  = '{0, 32'h0000_0020, 32'd4, 3, -1, 16'h0,  0, 0, 0, 1, 32'd0};
    vecs[5]  = '{0, 32'h0000_0030, 32'd2, 3, -1, 16'h0,  0, 0, 0, 1, 32'd0};
    vecs[6]  = '{1, 32'h0000_0055, 32'd3, 3, -1, 16'h0,  1, 1, 0, 0, 32'd0};
    vecs[7]  = '{0, 32'hFFFF_FFFE, 32'd3, 3, -1, 16'h0,  0, 1, 0, 0, 32'd0};
    vecs[8]  = '{1, 32'h0000_0033, 32'd2, 2,  0, 16'h54, 0, 0, 1, 0, 32'd0};
    vecs[9]  = '{0, 32'h0000_0060, 32'd0, 2, -1, 16'h0,  0, 0, 0, 1, 32'd0};
    vecs[10] = '{0, 32'h0000_0070, 32'd3, 2,  1, 16'h0,  1, 0, 1, 1, 32'd1};

    exp_frames[0] = '0; exp_frames[1] = '0;
    exp_fails[0]  = '0; exp_fails[1]  = '0;
    rst = 1'b1; enable = 1'b0; sel = 1'b0; length = '0; start = '0;
    tvalid = 1'b0; aclken = 1'b1; tlast = 1'b0; tdata = '0;

    tick(); tick();
    @(negedge clk);
    check("rst ready", r_ready, 0);
    check("rst tready", ax_r.tready, 0);
    check("rst done", r_done, 0);
    check("rst pass", r_pass, 0);
    check("rst err_data", r_err_data, 0);
    check("rst err_len", r_err_len, 0);
    check("rst err_index", r_err_index, 0);
    check("rst frame_cnt", r_frame_cnt, 0);
    check("rst fail_cnt", r_fail_cnt, 0);
    check("rst fixed ready", f_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", r_ready, 1);
    check("idle tready", ax_r.tready, 0);
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Enable held through RECV and REPORT must not re-arm; IDLE data is not consumed.
    arm(1'b0, 32'h40, 32'd2);
    enable = 1'b1;
    send_beat(16'h0040, 1'b0, 1'b0);
    check("enable in recv ready", ready_m, 0);
    send_beat(16'h0041, 1'b1, 1'b0);
    check("enable in report done", done_m, 1);
    check("enable in report pass", pass_m, 1);
    check("enable in report ready", ready_m, 0);
    enable = 1'b0;
    exp_frames[0] = exp_frames[0] + 32'd1;
    tvalid = 1'b1; tdata = 16'h1234;
    tick();
    check("idle ready", ready_m, 1);
    check("idle ignores data", tready_m, 0);
    check("idle frame_cnt", frame_cnt_m, exp_frames[0]);
    tvalid = 1'b0;

    // Reset after 2 of 8 beats: frame discarded, no done, counters cleared.
    arm(1'b0, 32'h0, 32'd8);
    send_beat(16'h0000, 1'b0, 1'b0);
    send_beat(16'h0001, 1'b0, 1'b0);
    rst = 1'b1; tvalid = 1'b1; tdata = 16'h0002;
    tick();
    check("midrst ready", ready_m, 0);
    check("midrst done", done_m, 0);
    check("midrst tready", tready_m, 0);
    check("midrst frame_cnt", frame_cnt_m, 0);
    check("midrst fail_cnt", fail_cnt_m, 0);
    check("midrst fixed frame_cnt", f_frame_cnt, 0);
    rst = 1'b0; tvalid = 1'b0; tlast = 1'b1;
    exp_frames[0] = '0; exp_frames[1] = '0;
    exp_fails[0]  = '0; exp_fails[1]  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst no done", done_m, 0);
      tick();
    end
    tlast = 1'b0;
    check("midrst ready back", ready_m, 1);
    run_vec('{0, 32'h0000_0100, 32'd2, 2, -1, 16'h0, 0, 1, 0, 0, 32'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
